// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit slice: bus widths,
// the implemented memory depth, the FSM state encoding and the request
// record carried through the request FIFO.
// ----------------------------------------------------------------------------
package lsu_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic              is_store;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the three buses around the load/store unit:
//   req_*  : execute -> LSU request handshake (valid/ready)
//   rsp_*  : LSU -> write-back response handshake (valid/ready)
//   mem_*  : LSU <-> data memory strobes, address and data
// The slave modport is the LSU's view; the master modport is the view of
// everything around it (execute, write-back and the memory together).
// ----------------------------------------------------------------------------
interface load_store_unit_if;
   import lsu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   logic [ADDR_W-1:0] mem_address;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_is_store, req_addr, req_wdata,
      input  rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output mem_address, mem_write, mem_read, mem_wdata
   );

   modport master (
      output req_valid, req_is_store, req_addr, req_wdata,
      output rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  mem_address, mem_write, mem_read, mem_wdata
   );

endinterface

// File: rtl/lsu_req_fifo.sv
// ----------------------------------------------------------------------------
// lsu_req_fifo
// Small synchronous FIFO of request records.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push     : write i_data (ignored while full)
//   i_data     : request to enqueue
//   i_pop      : drop the head entry (ignored while empty)
//   o_head     : current head entry (valid while !o_empty)
//   o_full     : no free entries
//   o_empty    : no entries
//   o_count    : number of stored entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module lsu_req_fifo
   import lsu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  req_t             i_data,
   input  logic             i_pop,
   output req_t             o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   req_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage in front of a MEM_DEPTH x DATA_W data memory.
// Requests from execute are buffered in a small FIFO; a three-state FSM
// (IDLE -> ACCESS -> RESP) issues one memory access at a time, strictly in
// order, and returns load data or range faults to write-back.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any access in flight and
//           discards a pending response
//   bus   : load_store_unit_if.slave
//             req_valid/req_ready/req_is_store/req_addr/req_wdata (in)
//             rsp_valid/rsp_ready/rsp_data/rsp_err            (out)
//             mem_address/mem_write/mem_read/mem_wdata/mem_rdata (memory)
//   busy  : FIFO holds a request or FSM is not IDLE
// Memory contract: write on posedge while mem_write is high; mem_rdata is
// valid after the negedge of a cycle with mem_read high.
// ----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_DEPTH  = lsu_pkg::MEM_DEPTH,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus,
   output logic               busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_ACCESS = ACCESS;
   localparam logic [1:0] ST_RESP   = RESP;

   // One extra bit so a depth equal to the full address space still compares
   // correctly.
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

   req_t             w_push_data;
   req_t             w_head;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic             w_pop;
   logic             w_in_range;

   logic [1:0]        r_state;
   logic              r_is_store;
   logic [ADDR_W-1:0] r_mem_address;
   logic              r_mem_write;
   logic              r_mem_read;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_rsp_data;

   assign w_push_data.is_store = bus.req_is_store;
   assign w_push_data.addr     = bus.req_addr;
   assign w_push_data.wdata    = bus.req_wdata;

   lsu_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (bus.req_valid),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.req_ready = !w_full;

   assign w_pop      = (r_state == ST_IDLE) && !w_empty;
   assign w_in_range = ({1'b0, w_head.addr} < MEM_LIMIT);

   assign bus.mem_address = r_mem_address;
   assign bus.mem_write   = r_mem_write;
   assign bus.mem_read    = r_mem_read;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.rsp_data    = r_rsp_data;

   assign busy = (w_count != '0) || (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_is_store    <= 1'b0;
         r_mem_address <= '0;
         r_mem_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_wdata   <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_data    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  if (w_in_range) begin
                     r_mem_address <= w_head.addr;
                     r_mem_wdata   <= w_head.wdata;
                     r_mem_write   <= w_head.is_store;
                     r_mem_read    <= !w_head.is_store;
                     r_is_store    <= w_head.is_store;
                     r_state       <= ST_ACCESS;
                  end else begin
                     // Faults skip the memory entirely, stores included,
                     // so mem_address never sees an out-of-range value.
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= '0;
                     r_state     <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               r_mem_write <= 1'b0;
               r_mem_read  <= 1'b0;
               if (r_is_store) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_rsp_data  <= bus.mem_rdata;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_mem_write <= 1'b0;
               r_mem_read  <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a behavioural 128 x 8 memory.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

   logic clk;
   logic rst_n;
   logic busy;
   logic preload;

   int numAsserts;
   int numFails;

   logic [7:0] memArr   [128];
   logic [7:0] modelMem [128];

   // Monitor state, written only by the monitor process
   int         readCycles;
   int         writeCycles;
   logic       bothStrobes;
   logic       badAddress;
   logic [8:0] rspQ [$];

   load_store_unit_if bus ();

   load_store_unit #(
      .MEM_DEPTH  (128),
      .FIFO_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Known contents for the preloaded locations, zero elsewhere
   function automatic logic [7:0] preloadVal(input int a);
      case (a)
         0:       return 8'd5;
         1:       return 8'd6;
         2:       return 8'd7;
         8:       return 8'd20;
         12:      return 8'd10;
         127:     return 8'h7F;
         default: return 8'h00;
      endcase
   endfunction

   // Memory write port: preload while 'preload' is high, else honour mem_write
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 128; i++) memArr[i] <= preloadVal(i);
      end else if (bus.mem_write) begin
         memArr[bus.mem_address[6:0]] <= bus.mem_wdata;
      end
   end

   // Memory read port: data becomes valid after the negedge of a read cycle
   always @(negedge clk) begin
      if (bus.mem_read) bus.mem_rdata <= memArr[bus.mem_address[6:0]];
   end

   // Monitor: counts strobe cycles, flags illegal strobe/address combinations
   // and logs every accepted response as {err, data}
   initial begin
      readCycles  = 0;
      writeCycles = 0;
      bothStrobes = 1'b0;
      badAddress  = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.mem_read)  readCycles++;
         if (bus.mem_write) writeCycles++;
         if (bus.mem_read && bus.mem_write) bothStrobes = 1'b1;
         if ((bus.mem_read || bus.mem_write) && bus.mem_address >= 8'd128) badAddress = 1'b1;
         if (bus.rsp_valid && bus.rsp_ready) rspQ.push_back({bus.rsp_err, bus.rsp_data});
      end
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numAsserts++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Offer one request from a negedge and hold it until accepted at a posedge;
   // returns 1 time unit after the accepting edge
   task automatic applyStimulus(input logic isStore, input logic [7:0] addr, input logic [7:0] wdata);
      int n;
      n = 0;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_is_store = isStore;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) checkOutput("push_timeout", 32'(bus.req_ready), 1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   // Wait (bounded) until the unit has drained
   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(busy), 0);
   endtask

   function automatic logic [8:0] rspAt(input int i);
      if (i < rspQ.size()) return rspQ[i];
      return 9'h1FF;
   endfunction

   int rdBase;
   int wrBase;
   int rspBase;
   int expCount;
   logic [8:0] expQ [$];
   logic       tSt   [9];
   logic [7:0] tAddr [9];
   logic [7:0] tData [9];

   initial begin
      numAsserts       = 0;
      numFails         = 0;
      rst_n            = 1'b0;
      preload          = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_addr     = 8'd0;
      bus.req_wdata    = 8'd0;
      bus.rsp_ready    = 1'b1;
      bus.mem_rdata    = 8'd0;
      for (int i = 0; i < 128; i++) modelMem[i] = preloadVal(i);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      preload = 1'b0;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 1);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      checkOutput("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 0);
      checkOutput("rst_mem_address", 32'(bus.mem_address), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load 8: one read cycle, response two cycles after acceptance
      rdBase  = readCycles;
      rspBase = rspQ.size();
      applyStimulus(1'b0, 8'd8, 8'd0);
      checkOutput("ld8_e0_read", 32'(bus.mem_read), 0);
      @(posedge clk); #1;
      checkOutput("ld8_e1_read", 32'(bus.mem_read), 1);
      checkOutput("ld8_e1_addr", 32'(bus.mem_address), 8);
      checkOutput("ld8_e1_rsp_valid", 32'(bus.rsp_valid), 0);
      @(posedge clk); #1;
      checkOutput("ld8_e2_read", 32'(bus.mem_read), 0);
      checkOutput("ld8_e2_rsp_valid", 32'(bus.rsp_valid), 1);
      checkOutput("ld8_e2_rsp_data", 32'(bus.rsp_data), 20);
      checkOutput("ld8_e2_rsp_err", 32'(bus.rsp_err), 0);
      waitIdle("ld8_idle");
      checkOutput("ld8_read_cycles", 32'(readCycles - rdBase), 1);
      checkOutput("ld8_rsp_count", 32'(rspQ.size() - rspBase), 1);

      // Store 3 <- A5 followed directly by load 3
      wrBase  = writeCycles;
      rspBase = rspQ.size();
      applyStimulus(1'b1, 8'd3, 8'hA5);
      applyStimulus(1'b0, 8'd3, 8'd0);
      waitIdle("st3_idle");
      checkOutput("st3_mem", 32'(memArr[3]), 32'hA5);
      checkOutput("st3_write_cycles", 32'(writeCycles - wrBase), 1);
      checkOutput("st3_rsp_count", 32'(rspQ.size() - rspBase), 1);
      checkOutput("ld3_rsp", 32'(rspAt(rspBase)), 32'h0A5);
      modelMem[3] = 8'hA5;

      // Range boundary: 127 is legal, 128/200 fault, a faulting store too
      rdBase  = readCycles;
      wrBase  = writeCycles;
      rspBase = rspQ.size();
      applyStimulus(1'b0, 8'd200, 8'd0);
      applyStimulus(1'b1, 8'd250, 8'h33);
      applyStimulus(1'b0, 8'd128, 8'd0);
      waitIdle("fault_idle");
      checkOutput("fault_read_cycles", 32'(readCycles - rdBase), 0);
      checkOutput("fault_write_cycles", 32'(writeCycles - wrBase), 0);
      checkOutput("fault_ld200_rsp", 32'(rspAt(rspBase)), 32'h100);
      checkOutput("fault_st250_rsp", 32'(rspAt(rspBase + 1)), 32'h100);
      checkOutput("fault_ld128_rsp", 32'(rspAt(rspBase + 2)), 32'h100);
      applyStimulus(1'b0, 8'd127, 8'd0);
      waitIdle("ld127_idle");
      checkOutput("ld127_rsp", 32'(rspAt(rspBase + 3)), 32'h07F);

      // Backpressure: hold rsp_ready low while loads 0,1,2 queue up
      bus.rsp_ready = 1'b0;
      rspBase = rspQ.size();
      applyStimulus(1'b0, 8'd0, 8'd0);
      applyStimulus(1'b0, 8'd1, 8'd0);
      applyStimulus(1'b0, 8'd2, 8'd0);
      checkOutput("bp_req_ready_full", 32'(bus.req_ready), 0);
      checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      checkOutput("bp_rsp_data", 32'(bus.rsp_data), 5);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_rsp_data_held", 32'(bus.rsp_data), 5);
      checkOutput("bp_rsp_valid_held", 32'(bus.rsp_valid), 1);
      checkOutput("bp_req_ready_held", 32'(bus.req_ready), 0);
      checkOutput("bp_no_early_rsp", 32'(rspQ.size() - rspBase), 0);
      bus.rsp_ready = 1'b1;
      waitIdle("bp_idle");
      checkOutput("bp_rsp_count", 32'(rspQ.size() - rspBase), 3);
      checkOutput("bp_rsp0", 32'(rspAt(rspBase)), 5);
      checkOutput("bp_rsp1", 32'(rspAt(rspBase + 1)), 6);
      checkOutput("bp_rsp2", 32'(rspAt(rspBase + 2)), 7);

      // Reset in the middle of a load's ACCESS cycle with another load queued
      rspBase = rspQ.size();
      applyStimulus(1'b0, 8'd12, 8'd0);
      applyStimulus(1'b0, 8'd0, 8'd0);
      checkOutput("rst_mid_read_before", 32'(bus.mem_read), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_strobes", 32'({bus.mem_read, bus.mem_write}), 0);
      checkOutput("rst_mid_rsp_valid", 32'(bus.rsp_valid), 0);
      checkOutput("rst_mid_busy", 32'(busy), 0);
      checkOutput("rst_mid_req_ready", 32'(bus.req_ready), 1);
      checkOutput("rst_mid_mem_address", 32'(bus.mem_address), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_mid_no_rsp", 32'(rspQ.size() - rspBase), 0);
      applyStimulus(1'b0, 8'd12, 8'd0);
      waitIdle("post_rst_idle");
      checkOutput("post_rst_rsp_count", 32'(rspQ.size() - rspBase), 1);
      checkOutput("post_rst_ld12", 32'(rspAt(rspBase)), 10);

      // Back-to-back mixed stream against an in-order reference model
      tSt[0] = 1'b1; tAddr[0] = 8'd20;  tData[0] = 8'h11;
      tSt[1] = 1'b0; tAddr[1] = 8'd20;  tData[1] = 8'h00;
      tSt[2] = 1'b0; tAddr[2] = 8'd8;   tData[2] = 8'h00;
      tSt[3] = 1'b1; tAddr[3] = 8'd21;  tData[3] = 8'h22;
      tSt[4] = 1'b0; tAddr[4] = 8'd200; tData[4] = 8'h00;
      tSt[5] = 1'b0; tAddr[5] = 8'd21;  tData[5] = 8'h00;
      tSt[6] = 1'b1; tAddr[6] = 8'd20;  tData[6] = 8'h33;
      tSt[7] = 1'b0; tAddr[7] = 8'd20;  tData[7] = 8'h00;
      tSt[8] = 1'b1; tAddr[8] = 8'd255; tData[8] = 8'h44;
      for (int i = 0; i < 9; i++) begin
         if (tAddr[i] >= 8'd128) expQ.push_back(9'h100);
         else if (tSt[i]) modelMem[tAddr[i][6:0]] = tData[i];
         else expQ.push_back({1'b0, modelMem[tAddr[i][6:0]]});
      end
      expCount = expQ.size();
      rspBase  = rspQ.size();
      for (int i = 0; i < 9; i++) applyStimulus(tSt[i], tAddr[i], tData[i]);
      waitIdle("stream_idle");
      checkOutput("stream_rsp_count", 32'(rspQ.size() - rspBase), 32'(expCount));
      for (int i = 0; i < expCount; i++) begin
         checkOutput($sformatf("stream_rsp%0d", i), 32'(rspAt(rspBase + i)), 32'(expQ[i]));
      end
      checkOutput("stream_mem20", 32'(memArr[20]), 32'(modelMem[20]));
      checkOutput("stream_mem21", 32'(memArr[21]), 32'(modelMem[21]));

      // Whole-run strobe invariants
      checkOutput("strobes_exclusive", 32'(bothStrobes), 0);
      checkOutput("address_in_range", 32'(badAddress), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage sitting directly upstream of the 128 x 8 data memory.
- Accepts load/store requests from execute through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the memory's address, write strobe, read strobe and write data. Captures read data and returns load results (and range faults) to write-back through a valid/ready handshake.
- Memory contract: writes on posedge while the write strobe is high; read data is valid after the negedge of a cycle in which the read strobe is high.

Parameters:
ADDR_W, 8, request/memory address width
DATA_W, 8, data width
MEM_DEPTH, 128, implemented words; an address >= MEM_DEPTH is a fault
FIFO_DEPTH, 2, request buffer entries (power of two)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  FIFO can accept (not full)
req_is_store  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data
rsp_valid  output  1  load result or fault available
rsp_ready  input  1  write-back accepts response
rsp_data  output  DATA_W  loaded value (0 on fault)
rsp_err  output  1  address out of range
mem_address  output  ADDR_W  to memory address
mem_write  output  1  to memory write strobe
mem_read  output  1  to memory read strobe
mem_wdata  output  DATA_W  to memory write data
mem_rdata  input  DATA_W  from memory read data
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): FIFO emptied; FSM=IDLE.
  - Outputs go to 0 immediately: mem_write, mem_read, mem_address, mem_wdata, rsp_valid, rsp_err, rsp_data.
  - req_ready=1.
  - Reset mid-access aborts the access; a pending response is discarded.
- Push: occurs at a posedge where req_valid & req_ready. req_ready = !full (purely from FIFO count).
  - Push and pop may occur in the same cycle at any occupancy below full.
  - At full, no push.
- All mem_* and rsp_* outputs are registered.
- FSM states:
  - IDLE: if FIFO non-empty, pop head.
    - Address in range: load mem_address/mem_wdata and set mem_write=is_store or mem_read=!is_store; go ACCESS.
    - Address >= MEM_DEPTH: no strobes; set rsp_valid=1, rsp_err=1, rsp_data=0; go RESP. Applies to loads and stores alike.
  - ACCESS: exactly one cycle with one strobe high.
    - Store: the posedge ending this cycle writes memory; clear strobe; go IDLE. Stores produce no response.
    - Load: at that posedge capture mem_rdata into rsp_data; set rsp_valid=1, rsp_err=0; clear strobe; go RESP.
  - RESP: hold rsp_valid/rsp_data/rsp_err stable until rsp_ready=1. On that edge clear rsp_valid/rsp_err; go IDLE.
- Latency and throughput:
  - Load accepted into an empty FIFO at edge E0: pop at E1, strobe high E1–E2, rsp_valid high from E2. Load latency is 2 cycles.
  - Store occupies 2 cycles (IDLE + ACCESS).
  - Requests are processed strictly in order. Only one access is outstanding, so load-after-store needs no forwarding.
- Backpressure: while in RESP, FIFO fill continues until full, then req_ready=0.
- Strobes are mutually exclusive and never high outside ACCESS.
- Address range check is unsigned compare against MEM_DEPTH; mem_address is never driven with an out-of-range value.

Decomposition:
- Package lsu_pkg:
  - ADDR_W/DATA_W/MEM_DEPTH constants
  - state enum {IDLE, ACCESS, RESP}
  - request struct {is_store, addr, wdata}
- Sub-module lsu_req_fifo:
  - parameterised synchronous FIFO of request structs
  - ports: push/pop/full/empty/count
  - async active-low reset

Test Plan:
- Memory preloaded [0]=5, [8]=20. Load addr 8 with rsp_ready=1 -> mem_read high exactly 1 cycle with mem_address=8; rsp_valid 2 cycles after acceptance, rsp_data=20, rsp_err=0.
- Store addr 3 data 0xA5, then load addr 3 -> memory[3]=0xA5; rsp_data=0xA5. Only one rsp_valid pulse, for the load.
- Load addr 200 -> no mem_read/mem_write ever high; rsp_valid with rsp_err=1, rsp_data=0.
- Hold rsp_ready=0 after load addr 0, then push loads 1 and 2 -> req_ready=0 after 2 buffered; rsp_data=5 held stable. Releasing rsp_ready yields 5, 6, 7 (preloaded [1]=6, [2]=7) in order.
- Assert rst_n=0 during ACCESS of a load addr 12 -> strobes and rsp_valid drop immediately, FIFO empty, busy=0. A post-reset load addr 12 returns 10.
- Back-to-back valid requests with rsp_ready=1 -> push/pop in the same cycle keeps order, and no request is lost or duplicated (scoreboard check).
